// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32I decode stage: control bundle layout, enums,
// opcode constants and immediate extraction helpers.
package rv_decode_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {RW_DISABLE, RW_ALU, RW_MEM, RW_PC} rw_src_e;
   typedef enum logic [1:0] {BRA_DISABLE, BRA_JMP, BRA_CMP, BRA_ALU} bra_mode_e;

   // Comparator selects, taken straight from funct3[2:1] of branches.
   localparam logic [1:0] CMP_EQ  = 2'b00;
   localparam logic [1:0] CMP_LT  = 2'b10;
   localparam logic [1:0] CMP_LTU = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic             rs1_used;
      logic             rs2_used;
      rw_src_e          rw_src;
      logic             alu_imm_b;
      logic             alu_pc_a;
      logic [2:0]       alu_op;
      logic             alu_alt;
      logic [XLEN-1:0]  imm;
      logic [1:0]       cmp_src;
      logic             cmp_inv;
      bra_mode_e        bra_mode;
      logic             mem_en;
      logic             mem_we;
      logic [2:0]       mem_func;
      logic             brk;
      logic             ecall;
      logic             illegal;
   } decode_t;

   localparam int DEC_W = $bits(decode_t);

   function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
      return {{(XLEN-12){i[31]}}, i[31:20]};
   endfunction

   function automatic logic [XLEN-1:0] imm_s(input logic [31:0] i);
      return {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
      return {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
      return {i[31:12], 12'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
      return {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction word to packed control
// bundle. Fields a format does not use are driven to zero.
module rv_decode_comb import rv_decode_pkg::*; #(
   parameter bit EN_SYSTEM = 1'b1,
   parameter bit EN_FENCE  = 1'b1
) (
   input  logic [31:0]      instr,
   output logic [DEC_W-1:0] dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       legal;
   decode_t    d;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign rd     = instr[11:7];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   always_comb begin
      d     = '0;
      legal = 1'b1;
      case (opcode)
         OPC_LUI: begin
            d.rd        = rd;
            d.rw_src    = RW_ALU;
            d.alu_imm_b = 1'b1;
            d.imm       = imm_u(instr);
         end
         OPC_AUIPC: begin
            d.rd        = rd;
            d.rw_src    = RW_ALU;
            d.alu_pc_a  = 1'b1;
            d.alu_imm_b = 1'b1;
            d.imm       = imm_u(instr);
         end
         OPC_JAL: begin
            d.rd       = rd;
            d.rw_src   = RW_PC;
            d.bra_mode = BRA_JMP;
            d.imm      = imm_j(instr);
         end
         OPC_JALR: begin
            legal       = (funct3 == 3'b000);
            d.rd        = rd;
            d.rs1       = rs1;
            d.rs1_used  = 1'b1;
            d.alu_op    = ALU_ADD;
            d.alu_imm_b = 1'b1;
            d.imm       = imm_i(instr);
            d.rw_src    = RW_PC;
            d.bra_mode  = BRA_ALU;
         end
         OPC_LOAD: begin
            legal       = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            d.rd        = rd;
            d.rs1       = rs1;
            d.rs1_used  = 1'b1;
            d.alu_op    = ALU_ADD;
            d.alu_imm_b = 1'b1;
            d.imm       = imm_i(instr);
            d.rw_src    = RW_MEM;
            d.mem_en    = 1'b1;
            d.mem_func  = funct3;
         end
         OPC_STORE: begin
            legal       = (funct3 inside {3'b000, 3'b001, 3'b010});
            d.rs1       = rs1;
            d.rs2       = rs2;
            d.rs1_used  = 1'b1;
            d.rs2_used  = 1'b1;
            d.alu_op    = ALU_ADD;
            d.alu_imm_b = 1'b1;
            d.imm       = imm_s(instr);
            d.mem_en    = 1'b1;
            d.mem_we    = 1'b1;
            d.mem_func  = funct3;
         end
         OPC_BRANCH: begin
            legal      = (funct3[2:1] inside {CMP_EQ, CMP_LT, CMP_LTU});
            d.rs1      = rs1;
            d.rs2      = rs2;
            d.rs1_used = 1'b1;
            d.rs2_used = 1'b1;
            d.alu_alt  = 1'b1;
            d.cmp_src  = funct3[2:1];
            d.cmp_inv  = funct3[0];
            d.imm      = imm_b(instr);
            d.bra_mode = BRA_CMP;
         end
         OPC_OP_IMM: begin
            // Shift-immediates carry a funct7 field that must be well formed.
            if (funct3 == 3'b001)
               legal = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101)
               legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            d.rd        = rd;
            d.rs1       = rs1;
            d.rs1_used  = 1'b1;
            d.alu_imm_b = 1'b1;
            d.alu_op    = funct3;
            d.alu_alt   = (funct3 == 3'b101) && instr[30];
            d.imm       = imm_i(instr);
            d.rw_src    = RW_ALU;
         end
         OPC_OP: begin
            legal      = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            d.rd       = rd;
            d.rs1      = rs1;
            d.rs2      = rs2;
            d.rs1_used = 1'b1;
            d.rs2_used = 1'b1;
            d.alu_op   = funct3;
            d.alu_alt  = instr[30];
            d.rw_src   = RW_ALU;
         end
         OPC_FENCE: begin
            legal = EN_FENCE && (funct3 inside {3'b000, 3'b001});
         end
         OPC_SYSTEM: begin
            if (EN_SYSTEM && (instr == INSTR_EBREAK))
               d.brk = 1'b1;
            else if (EN_SYSTEM && (instr == INSTR_ECALL))
               d.ecall = 1'b1;
            else
               legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         d         = '0;
         d.illegal = 1'b1;
      end else if (d.rd == 5'd0) begin
         d.rw_src = RW_DISABLE;
      end
   end

   assign dec = d;

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: combinational decode in front of an output register
// plus an optional skid entry, with valid/ready on both sides and flush.
module rv_decode_stage
   import rv_decode_pkg::DEC_W;
#(
   parameter int XLEN      = 32,
   parameter bit SKID      = 1'b1,
   parameter bit EN_SYSTEM = 1'b1,
   parameter bit EN_FENCE  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DEC_W-1:0] out_dec,
   output logic [XLEN-1:0]  out_pc
);

   logic [DEC_W-1:0] dec_bits;
   logic             out_valid_q;
   logic [DEC_W-1:0] out_dec_q;
   logic [XLEN-1:0]  out_pc_q;
   logic             skid_valid;
   logic [DEC_W-1:0] skid_dec;
   logic [XLEN-1:0]  skid_pc;
   logic             in_fire;
   logic             out_free;

   rv_decode_comb #(
      .EN_SYSTEM (EN_SYSTEM),
      .EN_FENCE  (EN_FENCE)
   ) u_comb (
      .instr (in_instr),
      .dec   (dec_bits)
   );

   // A transfer happens on a side in any cycle where its valid and ready are
   // both high; a held bundle stays unchanged until out_ready accepts it.
   assign out_free = !out_valid_q || out_ready;
   assign in_ready = rst ? 1'b0 : (SKID ? !skid_valid : out_free);
   assign in_fire  = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_dec_q   <= '0;
         out_pc_q    <= '0;
         skid_valid  <= 1'b0;
         skid_dec    <= '0;
         skid_pc     <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (out_free) begin
         // The skid entry is older than anything on the input, so it goes first.
         if (skid_valid) begin
            out_dec_q   <= skid_dec;
            out_pc_q    <= skid_pc;
            out_valid_q <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (in_fire) begin
            out_dec_q   <= dec_bits;
            out_pc_q    <= in_pc;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (in_fire) begin
         skid_dec   <= dec_bits;
         skid_pc    <= in_pc;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid = out_valid_q;
   assign out_dec   = out_dec_q;
   assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed decode and handshake scenarios followed by
// randomized traffic, scored against an occupancy/queue model and a decode model.
module tb_rv_decode_stage;
   import rv_decode_pkg::*;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [DEC_W-1:0] out_dec;
   logic [31:0]      out_pc;

   int vectors;
   int miscompares;
   logic [DEC_W+31:0] exp_q[$];
   logic              last_valid;
   logic [DEC_W-1:0]  last_dec;
   logic [31:0]       pc_ctr;

   rv_decode_stage #(
      .XLEN      (32),
      .SKID      (1'b1),
      .EN_SYSTEM (1'b1),
      .EN_FENCE  (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dec   (out_dec),
      .out_pc    (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference decoder written from the instruction-set rules.
   function automatic decode_t ref_decode(input logic [31:0] w);
      decode_t    d;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int         ii, is, ib, iu, ij;
      bit         legal;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      ii = $signed(w) >>> 20;
      is = int'($signed(w) >>> 25) * 32 + int'(w[11:7]);
      ib = int'($signed(w) >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      iu = int'(w & 32'hFFFF_F000);
      ij = int'($signed(w) >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      d = '0;
      legal = 1;
      if (op == 7'h37) begin
         d.rd = w[11:7]; d.rw_src = RW_ALU; d.alu_imm_b = 1; d.imm = iu;
      end else if (op == 7'h17) begin
         d.rd = w[11:7]; d.rw_src = RW_ALU; d.alu_pc_a = 1; d.alu_imm_b = 1; d.imm = iu;
      end else if (op == 7'h6F) begin
         d.rd = w[11:7]; d.rw_src = RW_PC; d.bra_mode = BRA_JMP; d.imm = ij;
      end else if (op == 7'h67) begin
         legal = (f3 == 0);
         d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs1_used = 1; d.alu_imm_b = 1; d.imm = ii;
         d.rw_src = RW_PC; d.bra_mode = BRA_ALU;
      end else if (op == 7'h03) begin
         legal = (f3 != 3 && f3 < 6);
         d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs1_used = 1; d.alu_imm_b = 1; d.imm = ii;
         d.rw_src = RW_MEM; d.mem_en = 1; d.mem_func = f3;
      end else if (op == 7'h23) begin
         legal = (f3 < 3);
         d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rs1_used = 1; d.rs2_used = 1;
         d.alu_imm_b = 1; d.imm = is; d.mem_en = 1; d.mem_we = 1; d.mem_func = f3;
      end else if (op == 7'h63) begin
         legal = (f3 != 2 && f3 != 3);
         d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rs1_used = 1; d.rs2_used = 1;
         d.cmp_src = f3[2:1]; d.cmp_inv = f3[0]; d.alu_alt = 1; d.imm = ib; d.bra_mode = BRA_CMP;
      end else if (op == 7'h13) begin
         if (f3 == 1) legal = (f7 == 0);
         if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
         d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs1_used = 1; d.alu_imm_b = 1; d.imm = ii;
         d.alu_op = f3; d.alu_alt = (f3 == 5) ? w[30] : 1'b0; d.rw_src = RW_ALU;
      end else if (op == 7'h33) begin
         legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
         d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rs1_used = 1; d.rs2_used = 1;
         d.alu_op = f3; d.alu_alt = w[30]; d.rw_src = RW_ALU;
      end else if (op == 7'h0F) begin
         legal = (f3 < 2);
      end else if (w == 32'h0010_0073) begin
         d.brk = 1;
      end else if (w == 32'h0000_0073) begin
         d.ecall = 1;
      end else begin
         legal = 0;
      end
      if (!legal) begin
         d = '0;
         d.illegal = 1;
      end else if (w[11:7] == 0) begin
         d.rw_src = RW_DISABLE;
      end
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  ops [0:10];
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h0F, 7'h73};
      w = $urandom();
      case ($urandom_range(0, 9))
         0: w = 32'h0000_0073;
         1: w = 32'h0010_0073;
         2: ;
         default: begin
            w[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1)
               w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
      endcase
      return w;
   endfunction

   // One clock: sample at the falling edge, score, update the model, then step.
   task automatic cycle();
      logic [DEC_W+31:0] e;
      logic in_fire;
      logic out_fire;
      @(negedge clk);
      check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
      check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
      last_valid = out_valid;
      last_dec   = out_dec;
      if (out_valid && exp_q.size() > 0) begin
         e = exp_q[0];
         check("out_dec", 128'(out_dec), 128'(e[DEC_W+31:32]));
         check("out_pc", 128'(out_pc), 128'(e[31:0]));
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_fire) exp_q.push_back({ref_decode(in_instr), in_pc});
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      in_valid = 1'b1;
      in_instr = w;
      in_pc    = pc_ctr;
      pc_ctr   = pc_ctr + 32'd4;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic send_and_peek(input logic [31:0] w, output decode_t d);
      send(w);
      cycle();
      check("peek_valid", 128'(last_valid), 128'(1'b1));
      d = decode_t'(last_dec);
   endtask

   task automatic check_illegal(input string tag, input logic [31:0] w);
      decode_t d;
      send_and_peek(w, d);
      check({tag, "_illegal"}, 128'(d.illegal), 128'(1'b1));
      check({tag, "_mem_en"}, 128'(d.mem_en), 128'(1'b0));
      check({tag, "_rw"}, 128'(d.rw_src), 128'(RW_DISABLE));
      check({tag, "_bra"}, 128'(d.bra_mode), 128'(BRA_DISABLE));
   endtask

   initial begin
      decode_t d;
      vectors     = 0;
      miscompares = 0;
      pc_ctr      = 32'h0000_1000;
      rst         = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_instr    = '0;
      in_pc       = '0;
      out_ready   = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(1'b0));
      check("rst_out_dec", 128'(out_dec), 128'(0));
      check("rst_out_pc", 128'(out_pc), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1'b0));
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed decodes with the output always ready
      out_ready = 1'b1;
      send_and_peek(32'h0050_0093, d);
      check("addi_rd", 128'(d.rd), 128'(5'd1));
      check("addi_rs1", 128'(d.rs1), 128'(5'd0));
      check("addi_rs1_used", 128'(d.rs1_used), 128'(1'b1));
      check("addi_alu_op", 128'(d.alu_op), 128'(3'b000));
      check("addi_imm_b", 128'(d.alu_imm_b), 128'(1'b1));
      check("addi_imm", 128'(d.imm), 128'(32'd5));
      check("addi_rw", 128'(d.rw_src), 128'(RW_ALU));

      send_and_peek(32'h4020_D1B3, d);
      check("sra_alu_op", 128'(d.alu_op), 128'(3'b101));
      check("sra_alt", 128'(d.alu_alt), 128'(1'b1));
      check("sra_rs2", 128'(d.rs2), 128'(5'd2));
      check("sra_rs2_used", 128'(d.rs2_used), 128'(1'b1));
      check("sra_imm_b", 128'(d.alu_imm_b), 128'(1'b0));

      send_and_peek(32'hFE20_9EE3, d);
      check("bne_bra", 128'(d.bra_mode), 128'(BRA_CMP));
      check("bne_cmp_src", 128'(d.cmp_src), 128'(2'b00));
      check("bne_cmp_inv", 128'(d.cmp_inv), 128'(1'b1));
      check("bne_imm", 128'(d.imm), 128'(32'hFFFF_FFFC));
      check("bne_rw", 128'(d.rw_src), 128'(RW_DISABLE));

      check_illegal("zero", 32'h0000_0000);
      check_illegal("op7b", 32'h0000_707B);
      check_illegal("slli_f7", 32'h4010_9093);

      send_and_peek(32'h0010_0073, d);
      check("ebreak_brk", 128'(d.brk), 128'(1'b1));
      check("ebreak_illegal", 128'(d.illegal), 128'(1'b0));

      // Backpressure: A on output, B in skid, C refused until release
      out_ready = 1'b0;
      send(32'h0010_0113);
      send(32'h0020_0193);
      send(32'h0030_0213);
      check("skid_full_in_ready", 128'(in_ready), 128'(1'b0));
      in_valid  = 1'b1;
      in_instr  = 32'h0030_0213;
      in_pc     = pc_ctr - 32'd4;
      out_ready = 1'b1;
      repeat (2) cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      check("abc_drained", 128'(exp_q.size()), 128'(0));

      // Flush while the skid is full and a new instruction is offered
      out_ready = 1'b0;
      send(32'h0040_0293);
      send(32'h0050_0313);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h0060_0393;
      in_pc    = 32'hDEAD_0000;
      cycle();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) cycle();

      // Flush with the stage empty drops the same-cycle input
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h0070_0413;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      repeat (2) cycle();

      // Asynchronous reset in the middle of backpressure
      out_ready = 1'b0;
      send(32'h0080_0493);
      send(32'h0090_0513);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 128'(out_valid), 128'(1'b0));
      check("arst_out_dec", 128'(out_dec), 128'(0));
      check("arst_in_ready", 128'(in_ready), 128'(1'b0));
      exp_q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_and_peek(32'h0050_0093, d);
      check("post_rst_rd", 128'(d.rd), 128'(5'd1));
      check("post_rst_imm", 128'(d.imm), 128'(32'd5));

      // Randomized traffic with random stalls and occasional flushes
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = rand_instr();
         in_pc     = $urandom();
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
